// File: rtl/jtag_mem_ctrl_pkg.sv
// Shared constants for the JTAG memory/engine controller: opcodes, FSM
// state encoding and the fixed status-word tags reported on tx_data.
// Ports: none (package only).
package jtag_mem_ctrl_pkg;

    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_READ   = 4'd2;
    localparam logic [3:0] OP_RUN    = 4'd3;
    localparam logic [3:0] OP_CLRERR = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_RUN
    } state_e;

    // RUN completion status: prefix OR'd with the saturated cycle count.
    localparam logic [31:0] RUN_STATUS_PREFIX = 32'hD0E0_0000;
    // WRITE completion status tag (upper half) when checksumming is off.
    localparam logic [15:0] WR_STATUS_TAG     = 16'hA5A5;

endpackage

// File: rtl/jtag_mem_ctrl_if.sv
// Bundle of the controller's JTAG, memory and engine signals.
// master: the controller side (drives strobes, address, status, tx_data).
// slave: the environment side (drives rx words, read data, eng_done).
interface jtag_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       rx_data;
    logic              rx_rdy;
    logic [31:0]       tx_data;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              eng_start;
    logic              eng_done;
    logic              busy;
    logic              err;

    modport master (
        input  rx_data, rx_rdy, mem_rdata, eng_done,
        output tx_data, mem_we, mem_re, mem_addr, mem_wdata, eng_start, busy, err
    );

    modport slave (
        output rx_data, rx_rdy, mem_rdata, eng_done,
        input  tx_data, mem_we, mem_re, mem_addr, mem_wdata, eng_start, busy, err
    );
endinterface

// File: rtl/jtag_cmd_decode.sv
// Combinational split of a JTAG command word into opcode/length/address.
// Ports: cmd (32-bit word in); opcode, len_m1 (length-1), addr, legal out.
// Latency 0; no state, no backpressure.
module jtag_cmd_decode
    import jtag_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [31:0]       cmd,
    output logic [3:0]        opcode,
    output logic [11:0]       len_m1,
    output logic [ADDR_W-1:0] addr,
    output logic              legal
);
    assign opcode = cmd[31:28];
    assign len_m1 = cmd[27:16];
    assign addr   = cmd[ADDR_W-1:0];
    assign legal  = (opcode == OP_WRITE) || (opcode == OP_READ) ||
                    (opcode == OP_RUN)   || (opcode == OP_CLRERR);

    // Address bits above the memory width are deliberately ignored.
    if (ADDR_W < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^cmd[15:ADDR_W];
    end
endmodule

// File: rtl/jtag_mem_ctrl.sv
// JTAG-driven memory burst read/write and collision-engine launch controller.
// Latency: memory strobes 1 cycle after rx_rdy; read data RD_LAT+1 cycles after mem_re.
// Backpressure: none; host paces by rx_rdy, words arriving in busy read/run states are dropped and flag err.
// Ports: clk, reset (sync, active-high), bus (jtag_mem_ctrl_if.master).
// Build option: JTAG_MEM_CTRL_CHECKSUM_EN reports a 32-bit sum of written data at WRITE exit.
module jtag_mem_ctrl
    import jtag_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    jtag_mem_ctrl_if.master bus
);
    state_e            state, state_nxt;

    logic [3:0]        cmd_op;
    logic [11:0]       cmd_len_m1;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_legal;

    logic [11:0]       len_m1_q;
    logic [11:0]       word_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              mem_we_q;
    logic              eng_start_q;
    logic [31:0]       tx_data_q;
    logic              err_q;
    logic [2:0]        lat_cnt;
    logic [15:0]       run_cyc;
    logic [31:0]       wr_status;

    logic              cmd_fire, wr_fire, rd_ack, rx_drop, lat_done, last_word;

    jtag_cmd_decode #(.ADDR_W(ADDR_W)) u_decode (
        .cmd    (bus.rx_data),
        .opcode (cmd_op),
        .len_m1 (cmd_len_m1),
        .addr   (cmd_addr),
        .legal  (cmd_legal)
    );

    assign last_word = (word_cnt == len_m1_q);
    assign lat_done  = (lat_cnt == 3'(RD_LAT));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.rx_rdy) begin
                    if      (cmd_op == OP_WRITE) state_nxt = ST_WR;
                    else if (cmd_op == OP_READ)  state_nxt = ST_RD_ISSUE;
                    else if (cmd_op == OP_RUN)   state_nxt = ST_RUN;
                end
            end
            ST_WR:       if (bus.rx_rdy && last_word) state_nxt = ST_IDLE;
            ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  if (lat_done) state_nxt = ST_RD_HOLD;
            ST_RD_HOLD:  if (bus.rx_rdy) state_nxt = last_word ? ST_IDLE : ST_RD_ISSUE;
            ST_RUN:      if (bus.eng_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        cmd_fire = (state == ST_IDLE) && bus.rx_rdy;
        wr_fire  = (state == ST_WR) && bus.rx_rdy;
        rd_ack   = (state == ST_RD_HOLD) && bus.rx_rdy;
        rx_drop  = bus.rx_rdy && ((state == ST_RD_ISSUE) || (state == ST_RD_WAIT) ||
                                  (state == ST_RUN));
        bus.busy   = (state != ST_IDLE);
        bus.mem_re = (state == ST_RD_ISSUE);
    end

`ifdef JTAG_MEM_CTRL_CHECKSUM_EN
    logic [31:0] wr_sum;

    always_ff @(posedge clk) begin
        if (reset)                                       wr_sum <= '0;
        else if (cmd_fire && cmd_op == OP_WRITE)         wr_sum <= '0;
        else if (wr_fire)                                wr_sum <= wr_sum + bus.rx_data;
    end

    // Includes the word being written in this cycle.
    assign wr_status = wr_sum + bus.rx_data;
`else
    assign wr_status = {WR_STATUS_TAG, 16'(len_m1_q) + 16'd1};
`endif

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            len_m1_q    <= '0;
            word_cnt    <= '0;
            wr_addr     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            eng_start_q <= 1'b0;
            tx_data_q   <= '0;
            err_q       <= 1'b0;
            lat_cnt     <= '0;
            run_cyc     <= '0;
        end else begin
            mem_we_q    <= wr_fire;
            eng_start_q <= cmd_fire && (cmd_op == OP_RUN);

            if (cmd_fire) begin
                if (cmd_op == OP_WRITE || cmd_op == OP_READ) begin
                    len_m1_q   <= cmd_len_m1;
                    word_cnt   <= '0;
                    wr_addr    <= cmd_addr;
                    mem_addr_q <= cmd_addr;
                end
                if (cmd_op == OP_RUN)         run_cyc <= '0;
                if (!cmd_legal)               err_q   <= 1'b1;
                else if (cmd_op == OP_CLRERR) err_q   <= 1'b0;
            end

            if (rx_drop) err_q <= 1'b1;

            // Address wraps modulo 2^ADDR_W by natural overflow.
            if (wr_fire) begin
                mem_addr_q  <= wr_addr;
                wr_addr     <= wr_addr + ADDR_W'(1);
                mem_wdata_q <= bus.rx_data;
                word_cnt    <= word_cnt + 12'd1;
                if (last_word) tx_data_q <= wr_status;
            end

            if (state == ST_RD_ISSUE) lat_cnt <= 3'd1;
            if (state == ST_RD_WAIT) begin
                if (lat_done) tx_data_q <= bus.mem_rdata;
                else          lat_cnt   <= lat_cnt + 3'd1;
            end

            if (rd_ack && !last_word) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                word_cnt   <= word_cnt + 12'd1;
            end

            // run_cyc is 0 in the entry cycle, so done-at-entry reports 0.
            if (state == ST_RUN) begin
                if (bus.eng_done)            tx_data_q <= RUN_STATUS_PREFIX | {16'h0000, run_cyc};
                else if (run_cyc != 16'hFFFF) run_cyc  <= run_cyc + 16'd1;
            end
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.eng_start = eng_start_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// Directed bench for jtag_mem_ctrl: write bursts scored against a queue of
// expected memory writes, reads through a 2-cycle memory model, RUN status,
// error handling and mid-burst reset.
module tb_jtag_mem_ctrl;
    localparam int AW = 10;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    jtag_mem_ctrl_if #(.ADDR_W(AW)) bus ();

    jtag_mem_ctrl #(.ADDR_W(AW), .RD_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with a two-cycle read pipeline.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_pipe0, rd_pipe1;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe0 <= bus.mem_re ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
        rd_pipe1 <= rd_pipe0;
    end
    assign bus.mem_rdata = rd_pipe1;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every memory write must match the next expected entry.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            chk("we_re_exclusive", {31'b0, bus.mem_re}, 32'h0);
            if (wq.size() == 0) begin
                chk("unexpected_mem_we", {22'b0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", {22'b0, bus.mem_addr}, {22'b0, e.a});
                chk("wr_data", bus.mem_wdata, e.d);
            end
        end
    end

    function automatic logic [31:0] cmd(input logic [3:0] op, input int len, input logic [15:0] a);
        logic [11:0] l;
        l = 12'(len - 1);
        return {op, l, a};
    endfunction

    // Called at posedge+1; presents one word for exactly one cycle.
    task automatic send(input logic [31:0] w);
        bus.rx_data = w;
        bus.rx_rdy  = 1'b1;
        @(posedge clk); #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    function automatic logic [31:0] wr_status(input logic [31:0] sum, input logic [15:0] n);
`ifdef JTAG_MEM_CTRL_CHECKSUM_EN
        return sum + {16'h0, n} - {16'h0, n};
`else
        return {16'hA5A5, n} + (sum - sum);
`endif
    endfunction

    int starts;

    initial begin
        reset       = 1'b1;
        bus.rx_rdy  = 1'b0;
        bus.rx_data = '0;
        bus.eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_tx_data",   bus.tx_data, 32'h0);
        chk("rst_strobes",   {29'b0, bus.mem_we, bus.mem_re, bus.eng_start}, 32'h0);
        chk("rst_mem_addr",  {22'b0, bus.mem_addr}, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_busy_err",  {30'b0, bus.busy, bus.err}, 32'h0);

        // WRITE len 3 @0x010
        push(10'h010, 32'h11); push(10'h011, 32'h22); push(10'h012, 32'h33);
        send(cmd(4'd1, 3, 16'h0010));
        chk("wr_busy", {31'b0, bus.busy}, 32'h1);
        send(32'h11); send(32'h22); send(32'h33);
        chk("wr3_idle", {31'b0, bus.busy}, 32'h0);
        chk("wr3_status", bus.tx_data, wr_status(32'h66, 16'd3));
        idle(2);

        // WRITE len 2 wrapping at top of memory; upper address bits ignored
        push(10'h3FF, 32'hCAFE_0001); push(10'h000, 32'hCAFE_0002);
        send(cmd(4'd1, 2, 16'hFFFF));
        send(32'hCAFE_0001); send(32'hCAFE_0002);
        chk("wr2_status", bus.tx_data, wr_status(32'h95FC_0003, 16'd2));
        idle(2);

        // Preload mem[5]/mem[6] through the controller
        push(10'd5, 32'h0000_AAAA); push(10'd6, 32'h0000_BBBB);
        send(cmd(4'd1, 2, 16'd5));
        send(32'h0000_AAAA); send(32'h0000_BBBB);
        idle(2);

        // READ len 2 @5
        send(cmd(4'd2, 2, 16'd5));
        chk("rd_mem_re", {31'b0, bus.mem_re}, 32'h1);
        chk("rd_addr0", {22'b0, bus.mem_addr}, 32'd5);
        idle(4);
        chk("rd_data0", bus.tx_data, 32'h0000_AAAA);
        idle(2);
        chk("rd_hold0", bus.tx_data, 32'h0000_AAAA);
        chk("rd_busy0", {31'b0, bus.busy}, 32'h1);
        send(32'h1234_5678);
        chk("rd_addr1", {22'b0, bus.mem_addr}, 32'd6);
        idle(4);
        chk("rd_data1", bus.tx_data, 32'h0000_BBBB);
        chk("rd_busy1", {31'b0, bus.busy}, 32'h1);
        send(32'h0);
        chk("rd_done_busy", {31'b0, bus.busy}, 32'h0);
        chk("rd_done_tx", bus.tx_data, 32'h0000_BBBB);
        idle(2);

        // RUN with eng_done 10 cycles after eng_start
        send(cmd(4'd3, 1, 16'd0));
        chk("run_start", {31'b0, bus.eng_start}, 32'h1);
        starts = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.eng_start) starts++;
        end
        bus.eng_done = 1'b1;
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
        chk("run_extra_starts", starts, 32'd0);
        chk("run_status", bus.tx_data, 32'hD0E0_000A);
        chk("run_idle", {31'b0, bus.busy}, 32'h0);
        idle(2);

        // RUN with eng_done in the entry cycle
        send(cmd(4'd3, 1, 16'd0));
        bus.eng_done = 1'b1;
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
        chk("run0_status", bus.tx_data, 32'hD0E0_0000);
        chk("run0_idle", {31'b0, bus.busy}, 32'h0);

        // eng_done outside RUN is ignored
        bus.eng_done = 1'b1;
        @(posedge clk); #1;
        bus.eng_done = 1'b0;
        chk("done_in_idle", {31'b0, bus.busy}, 32'h0);
        chk("done_in_idle_tx", bus.tx_data, 32'hD0E0_0000);

        // Illegal opcodes and CLRERR
        send(32'hF000_0000);
        chk("err_opF", {31'b0, bus.err}, 32'h1);
        chk("err_opF_idle", {31'b0, bus.busy}, 32'h0);
        send(cmd(4'd4, 1, 16'd0));
        chk("clrerr", {31'b0, bus.err}, 32'h0);
        send(32'h0000_0000);
        chk("err_op0", {31'b0, bus.err}, 32'h1);
        send(cmd(4'd4, 1, 16'd0));
        chk("clrerr2", {31'b0, bus.err}, 32'h0);

        // rx_rdy during RD_WAIT: flagged and dropped, read still completes
        send(cmd(4'd2, 1, 16'd5));
        idle(1);
        send(32'hBAD0_BAD0);
        chk("rdwait_err", {31'b0, bus.err}, 32'h1);
        chk("rdwait_busy", {31'b0, bus.busy}, 32'h1);
        idle(1);
        chk("rdwait_data", bus.tx_data, 32'h0000_AAAA);
        send(32'h0);
        chk("rdwait_done", {31'b0, bus.busy}, 32'h0);
        chk("rdwait_err_sticky", {31'b0, bus.err}, 32'h1);

        // Reset after first word of WRITE len 4 (err still set beforehand)
        push(10'h020, 32'h0000_0001);
        send(cmd(4'd1, 4, 16'h0020));
        send(32'h0000_0001);
        reset       = 1'b1;
        bus.rx_data = 32'h0000_0002;
        bus.rx_rdy  = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        bus.rx_rdy = 1'b0;
        chk("mrst_strobes", {29'b0, bus.mem_we, bus.mem_re, bus.eng_start}, 32'h0);
        chk("mrst_busy_err", {30'b0, bus.busy, bus.err}, 32'h0);
        chk("mrst_tx", bus.tx_data, 32'h0);
        chk("mrst_addr", {22'b0, bus.mem_addr}, 32'h0);
        chk("mrst_wdata", bus.mem_wdata, 32'h0);
        idle(6);
        chk("wq_empty", wq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
